mux_4bit_rr: RTL

//   4:1 collecting multiplexer, the return path for demux_4bit fan-out: merges four

---
 rtl/mux_4bit_rr.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_4bit_rr.sv
// mux_4bit_rr -- 4:1 collecting multiplexer with a registered output stage.
//
// Four valid/ready input channels are merged into one output stream. When the
// output register can take a beat, one requesting channel is granted and its
// data moves into the output register on the next rising edge. sel_out records
// which channel produced the beat, so downstream logic can route replies back.
//
// Arbitration is round-robin. The search starts at the channel after the most
// recently granted one. After reset, channel 0 has the highest priority.
//
// Build option:
//   MUX_4BIT_RR_FIXED_PRIO_EN -- when defined, arbitration uses fixed priority
//   (ch0 > ch1 > ch2 > ch3) and the pointer register is removed. Handshake,
//   latency and reset values do not change.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   data_in0-3 in   DATA_W  channel data
//   in_valid   in   4       per-channel beat present
//   in_ready   out  4       per-channel beat accepted this cycle (one-hot or 0)
//   data_out   out  DATA_W  registered output data
//   sel_out    out  2       source channel of data_out
//   out_valid  out  1       output register holds a beat
//   out_ready  in   1       downstream accepts the held beat

module mux_4bit_rr #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        sel_out,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        prio_base;  // search begins at prio_base + 1
  logic              load_en;
  logic              found;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [3:0]        grant;

  logic [DATA_W-1:0] data_arr [4];

  assign data_arr[0] = data_in0;
  assign data_arr[1] = data_in1;
  assign data_arr[2] = data_in2;
  assign data_arr[3] = data_in3;

`ifdef MUX_4BIT_RR_FIXED_PRIO_EN
  // A base of 3 makes the search order 0,1,2,3 on every cycle.
  assign prio_base = 2'b11;
`else
  logic [1:0] last_q, last_d;
  assign prio_base = last_q;
`endif

  // Load the output register when it is empty, or when its beat leaves this cycle.
  assign load_en = (state_q == EMPTY) || out_ready;

  // Arbiter: first requester after prio_base, wrapping modulo 4.
  // Gated by rst so no beat is accepted while reset is held.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    if (load_en && !rst) begin
      for (int k = 1; k <= 4; k++) begin
        cand = prio_base + 2'(k);
        if (!found && in_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign grant    = found ? (4'b0001 << grant_idx) : 4'b0000;
  assign in_ready = grant;

  // Output-stage next state.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifndef MUX_4BIT_RR_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    if (found) begin
      state_d = FULL;
      data_d  = data_arr[grant_idx];
      sel_d   = grant_idx;
`ifndef MUX_4BIT_RR_FIXED_PRIO_EN
      last_d  = grant_idx;
`endif
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'd0;
`ifndef MUX_4BIT_RR_FIXED_PRIO_EN
      last_q  <= 2'b11;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef MUX_4BIT_RR_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign data_out  = data_q;
  assign sel_out   = sel_q;

endmodule
